// File: rtl/ror32_seq.sv
// ror32_seq: sequential 32-bit rotator, one bit per clock.
// Loads operand and amount (num_shifts mod 32) on start in IDLE, rotates once
// per SHIFT cycle, then pulses done for one cycle. All outputs are registered.
// Optional feature: define ROR32_SEQ_DIR_EN to add a 'dir' input
// (1 = rotate left, 0 = rotate right), sampled together with start.
module ror32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] in,
    input  logic signed [WIDTH-1:0] num_shifts,
`ifdef ROR32_SEQ_DIR_EN
    input  logic                    dir,
`endif
    output logic signed [WIDTH-1:0] out,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   rot_r;
    logic [CNT_W-1:0]   amt;

    // Only the low bits of the amount matter: rotation is modulo WIDTH.
    logic unused_num_shifts_hi;
    assign unused_num_shifts_hi = ^num_shifts[WIDTH-1:CNT_W];

    assign amt   = num_shifts[CNT_W-1:0];
    assign rot_r = {work_q[0], work_q[WIDTH-1:1]};

`ifdef ROR32_SEQ_DIR_EN
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_step;
    assign rot_l    = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
    assign rot_step = dir_q ? rot_l : rot_r;

    // Direction latch, captured with the accepted start.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    logic [WIDTH-1:0] rot_step;
    assign rot_step = rot_r;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
`ifdef ROR32_SEQ_DIR_EN
        dir_d   = dir_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    work_d  = in;
                    cnt_d   = amt;
`ifdef ROR32_SEQ_DIR_EN
                    dir_d   = dir;
`endif
                    state_d = (amt != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                work_d = rot_step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StShift);
        done_d = (state_d == StDone);
    end

    // State, datapath and output flops; reset clears everything at once.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StIdle;
            work_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = work_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ror32_seq.sv
// Directed, table-driven bench for ror32_seq plus hand-written corner sequences.
module tb_ror32_seq;

    logic               clk;
    logic               clr_n;
    logic               start;
    logic signed [31:0] in;
    logic signed [31:0] num_shifts;
    logic               dir;
    logic signed [31:0] out;
    logic               busy;
    logic               done;

    int n_cmp  = 0;
    int n_fail = 0;

    ror32_seq #(
        .WIDTH(32),
        .CNT_W(5)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .in        (in),
        .num_shifts(num_shifts),
`ifdef ROR32_SEQ_DIR_EN
        .dir       (dir),
`endif
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [31:0] ns;
        logic [31:0] exp_out;
        int          exp_n;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One full operation: start at E0, measure busy cycles, done cycle, result.
    task automatic do_op(input string nm, input logic [31:0] din, input logic [31:0] ns,
                         input logic [31:0] exp_out, input int exp_n);
        int cyc;
        int bc;
        @(negedge clk);
        start      = 1'b1;
        in         = din;
        num_shifts = ns;
        @(posedge clk);
        #1;
        start      = 1'b0;
        in         = 32'hDEAD_BEEF;
        num_shifts = 32'd7;
        cyc = 1;
        bc  = 0;
        while (!done && cyc <= 40) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, " done_seen"}, {31'd0, done}, 32'd1);
        chk({nm, " done_cycle"}, cyc, exp_n + 1);
        chk({nm, " busy_cycles"}, bc, exp_n);
        chk({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({nm, " out"}, out, exp_out);
        @(posedge clk);
        #1;
        chk({nm, " done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({nm, " out_held"}, out, exp_out);
    endtask

    initial begin
        int dcount;
        vecs[0] = '{32'h0000_0001, 32'd1,          32'h8000_0000, 1};
        vecs[1] = '{32'h1234_5678, 32'd0,          32'h1234_5678, 0};
        vecs[2] = '{32'h1234_5678, 32'd32,         32'h1234_5678, 0};
        vecs[3] = '{32'h8000_0001, 32'hFFFF_FFFF,  32'h0000_0003, 31};
        vecs[4] = '{32'hF000_0000, 32'd4,          32'h0F00_0000, 4};
        vecs[5] = '{32'h0000_000A, 32'd1,          32'h0000_0005, 1};
        vecs[6] = '{32'h1234_5678, 32'd8,          32'h7812_3456, 8};
        vecs[7] = '{32'h0000_0003, 32'd33,         32'h8000_0001, 1};

        clr_n = 1'b0;
        start = 1'b0;
        in = '0;
        num_shifts = '0;
        dir = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", out, 32'h0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        clr_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].din, vecs[i].ns, vecs[i].exp_out,
                  vecs[i].exp_n);
        end

        // Start asserted during SHIFT must be ignored.
        @(negedge clk);
        start = 1'b1; in = 32'hF000_0000; num_shifts = 32'd4;
        @(posedge clk); #1;
        in = 32'h1; num_shifts = 32'd1;
        start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); @(negedge clk); start = 1'b0;
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("ignore_start done_pulses", dcount, 1);
        chk("ignore_start out", out, 32'h0F00_0000);

        // Continuous start: re-accepted on the first IDLE cycle after DONE.
        @(negedge clk);
        start = 1'b1; in = 32'h0000_0004; num_shifts = 32'd2;
        @(posedge clk); #1;              // cycle 1
        @(posedge clk); #1;              // cycle 2
        @(posedge clk); #1;              // cycle 3: DONE
        chk("hold_start done", {31'd0, done}, 32'd1);
        chk("hold_start out1", out, 32'h0000_0001);
        @(posedge clk); #1;              // cycle 4: IDLE
        chk("hold_start idle busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;              // cycle 5: restarted
        chk("hold_start restarted", {31'd0, busy}, 32'd1);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_start out2", out, 32'h0000_0001);

        // Asynchronous reset mid-SHIFT aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; in = 32'h1234_5678; num_shifts = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        chk("async_rst out", out, 32'h0);
        chk("async_rst busy", {31'd0, busy}, 32'd0);
        chk("async_rst done", {31'd0, done}, 32'd0);
        dcount = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        chk("async_rst quiet", dcount, 0);
        // Release, then start is presented for the very first edge after release.
        clr_n = 1'b1;
        do_op("after_rst", 32'h0000_000A, 32'd1, 32'h0000_0005, 1);

`ifdef ROR32_SEQ_DIR_EN
        dir = 1'b1;
        do_op("dir_left", 32'h8000_0000, 32'd1, 32'h0000_0001, 1);
        dir = 1'b0;
        do_op("dir_right", 32'h8000_0000, 32'd1, 32'h4000_0000, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
